// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two valid/ready
// requesters. One transaction in flight; operands and results are registered.
module alu_share_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CTL_W     = 4,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTL_W-1:0] req0_op,
  input  logic [CTL_W-1:0] req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CTL_W-1:0] op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             zero;
    logic             err;
  } rsp_t;

  // Codes 4'b1010 and above have no ALU function behind them.
  localparam logic [CTL_W-1:0] OP_UNDEF = CTL_W'(10);

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   owner_q, owner_d;
  req_t   alu_q, alu_d;
  rsp_t   rsp_q, rsp_d;

  logic   gnt_vld;
  logic   gnt;
  logic   accept;
  req_t   req_sel;

  always_comb begin
    gnt_vld = req_valid[prio_q] | req_valid[~prio_q];
    gnt     = req_valid[prio_q] ? prio_q : ~prio_q;
    // Gated with rst_n so no handshake is offered while reset is held.
    accept  = (state_q == IDLE) && gnt_vld && rst_n;
    req_sel = gnt ? '{a: req1_a, b: req1_b, op: req1_op}
                  : '{a: req0_a, b: req0_b, op: req0_op};
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    alu_d   = alu_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_d   = req_sel;
          owner_d = gnt;
          prio_d  = ~gnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_d.y    = alu_y;
        rsp_d.ovf  = alu_ovf;
        rsp_d.zero = alu_zero;
        rsp_d.err  = (alu_q.op >= OP_UNDEF);
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= PRIO_INIT;
      owner_q <= 1'b0;
      alu_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      alu_q   <= alu_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    busy      = (state_q != IDLE);
    alu_a     = alu_q.a;
    alu_b     = alu_q.b;
    alu_ctl   = alu_q.op;
    rsp_y     = rsp_q.y;
    rsp_ovf   = rsp_q.ovf;
    rsp_zero  = rsp_q.zero;
    rsp_err   = rsp_q.err;
  end

endmodule
